// File: rtl/count_monitor.sv
// Monitors an upstream 4-bit counter: locks after SYNC_LEN consecutive +1 steps,
// flags sequence breaks while locked and counts 15->0 wraps seen while tracking.
module count_monitor #(
  parameter int SYNC_LEN = 2,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [3:0]        q_in,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [3:0]        last_q,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [3:0]        SYNC_LEN_C = 4'(SYNC_LEN);
  localparam logic [WRAP_W-1:0] WRAP_MAX   = '1;

  state_t              state_q, state_d;
  logic [3:0]          good_cnt_q, good_cnt_d;
  logic [3:0]          last_q_d;
  logic                locked_d, err_d, err_sticky_d, wrap_pulse_d;
  logic [WRAP_W-1:0]   wrap_count_d;
  logic                is_good, is_hold, is_wrap;

  // Classification is always against the previously accepted sample.
  assign is_good = (q_in == last_q + 4'd1);
  assign is_hold = (q_in == last_q);
  assign is_wrap = is_good && (last_q == 4'hF);

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    last_q_d     = last_q;
    err_d        = 1'b0;
    wrap_pulse_d = 1'b0;
    err_sticky_d = err_sticky;
    wrap_count_d = wrap_count;
    if (sample_en) begin
      last_q_d = q_in;
      unique case (state_q)
        IDLE: begin
          state_d    = SYNC;
          good_cnt_d = 4'd0;
        end
        SYNC: begin
          if (is_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 >= SYNC_LEN_C) begin
              state_d    = TRACK;
              good_cnt_d = 4'd0;
            end
          end else if (!is_hold) begin
            good_cnt_d = 4'd0;
          end
        end
        TRACK: begin
          if (is_wrap) begin
            wrap_pulse_d = 1'b1;
            if (wrap_count != WRAP_MAX) wrap_count_d = wrap_count + 1'b1;
          end else if (!is_good && !is_hold) begin
            state_d      = ERROR;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end
        end
        ERROR: begin
          if (!is_hold) begin
            state_d    = SYNC;
            good_cnt_d = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      good_cnt_q <= 4'd0;
      last_q     <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      last_q     <= last_q_d;
      locked     <= locked_d;
      err        <= err_d;
      err_sticky <= err_sticky_d;
      wrap_pulse <= wrap_pulse_d;
      wrap_count <= wrap_count_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock, wrap, break, re-lock, hold/gaps,
// wrap-counter saturation with a 2-bit counter, and mid-stream reset.
module tb_count_monitor;

  localparam int WRAP_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_en;
  logic [3:0]        q_in;
  logic              locked, err, err_sticky, wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [3:0]        last_q;
  logic [1:0]        state;

  int checks   = 0;
  int failures = 0;

  count_monitor #(.SYNC_LEN(2), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .q_in       (q_in),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .last_q     (last_q),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample at a falling edge; outputs are checked at the next falling edge.
  task automatic samp(input logic [3:0] v);
    @(negedge clk);
    sample_en = 1'b1;
    q_in      = v;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},  16'(state), 16'd0);
    chk({tag, "_locked"}, 16'(locked), 16'd0);
    chk({tag, "_err"},    16'(err), 16'd0);
    chk({tag, "_sticky"}, 16'(err_sticky), 16'd0);
    chk({tag, "_wrap"},   16'(wrap_pulse), 16'd0);
    chk({tag, "_wcnt"},   16'(wrap_count), 16'd0);
    chk({tag, "_lastq"},  16'(last_q), 16'd0);
  endtask

  initial begin
    int wraps;
    rst = 1'b1; sample_en = 1'b0; q_in = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // Lock: 3,4,5
    samp(4'd3); chk("lock3_state", 16'(state), 16'd1); chk("lock3_lastq", 16'(last_q), 16'd3);
    samp(4'd4); chk("lock4_state", 16'(state), 16'd1); chk("lock4_locked", 16'(locked), 16'd0);
    samp(4'd5); chk("lock5_state", 16'(state), 16'd2); chk("lock5_locked", 16'(locked), 16'd1);

    // Wrap: advance to 13 while tracking, then 14,15,0,1
    for (int v = 6; v <= 13; v++) begin
      samp(4'(v)); chk("adv_state", 16'(state), 16'd2);
    end
    samp(4'd14); chk("w14_pulse", 16'(wrap_pulse), 16'd0);
    samp(4'd15); chk("w15_pulse", 16'(wrap_pulse), 16'd0);
    samp(4'd0);  chk("w0_pulse", 16'(wrap_pulse), 16'd1); chk("w0_wcnt", 16'(wrap_count), 16'd1);
    idle_cycle(); chk("w_gap_pulse", 16'(wrap_pulse), 16'd0);
    samp(4'd1);  chk("w1_pulse", 16'(wrap_pulse), 16'd0); chk("w1_wcnt", 16'(wrap_count), 16'd1);

    // Break: advance to 6, then 9
    for (int v = 2; v <= 6; v++) samp(4'(v));
    chk("brk6_state", 16'(state), 16'd2);
    chk("brk6_sticky", 16'(err_sticky), 16'd0);
    samp(4'd9);
    chk("brk_err", 16'(err), 16'd1);
    chk("brk_sticky", 16'(err_sticky), 16'd1);
    chk("brk_state", 16'(state), 16'd3);
    chk("brk_locked", 16'(locked), 16'd0);
    idle_cycle();
    chk("brk_err_clear", 16'(err), 16'd0);
    chk("brk_sticky_hold", 16'(err_sticky), 16'd1);
    chk("brk_state_hold", 16'(state), 16'd3);

    // Re-lock: 2,3,4
    samp(4'd2); chk("rl2_state", 16'(state), 16'd1); chk("rl2_err", 16'(err), 16'd0);
    samp(4'd3); chk("rl3_state", 16'(state), 16'd1);
    samp(4'd4); chk("rl4_state", 16'(state), 16'd2); chk("rl4_sticky", 16'(err_sticky), 16'd1);

    // Hold and gaps at 7
    samp(4'd5); samp(4'd6); samp(4'd7);
    chk("hg7_state", 16'(state), 16'd2);
    samp(4'd7);
    chk("hg_hold_state", 16'(state), 16'd2); chk("hg_hold_err", 16'(err), 16'd0);
    chk("hg_hold_lastq", 16'(last_q), 16'd7);
    for (int i = 0; i < 5; i++) begin
      idle_cycle(); chk("hg_gap_state", 16'(state), 16'd2); chk("hg_gap_err", 16'(err), 16'd0);
    end
    samp(4'd8);
    chk("hg8_state", 16'(state), 16'd2); chk("hg8_err", 16'(err), 16'd0);
    chk("hg8_lastq", 16'(last_q), 16'd8);

    // Saturation: four more wraps (five total) on a 2-bit wrap counter
    for (int v = 9; v <= 15; v++) samp(4'(v));
    wraps = 1;
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v <= 15; v++) begin
        samp(4'(v));
        if (v == 0) begin
          wraps++;
          chk("sat_pulse", 16'(wrap_pulse), 16'd1);
          chk("sat_wcnt", 16'(wrap_count), 16'((wraps > 3) ? 3 : wraps));
        end
      end
    end
    chk("sat_final_wcnt", 16'(wrap_count), 16'd3);
    chk("sat_state", 16'(state), 16'd2);

    // Reset mid-stream, overriding a concurrent sample
    @(negedge clk);
    rst = 1'b1; sample_en = 1'b1; q_in = 4'd0;
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0;
    chk_all_zero("midrst");

    // Bad step in SYNC clears the good count without err
    samp(4'd1); samp(4'd2);
    chk("sb2_state", 16'(state), 16'd1);
    samp(4'd9);
    chk("sb9_state", 16'(state), 16'd1); chk("sb9_err", 16'(err), 16'd0);
    samp(4'd10);
    chk("sb10_state", 16'(state), 16'd1);
    samp(4'd11);
    chk("sb11_state", 16'(state), 16'd2); chk("sb11_sticky", 16'(err_sticky), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
